// File: rtl/id_hazard_ctrl_if.sv
// ID-stage hazard controller bus: pipeline register fields in, stall/flush
// controls and performance counters out.
interface id_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       IF_ID_rs;
  logic [4:0]       IF_ID_rt;
  logic             IF_ID_UseRs;
  logic             IF_ID_UseRt;
  logic             IF_ID_Branch;
  logic [4:0]       ID_EX_regres;
  logic             ID_EX_MEMRead;
  logic             ID_EX_RegWrite;
  logic [4:0]       EX_MEM_regres;
  logic             EX_MEM_MEMRead;
  logic             EX_MEM_RegWrite;
  logic             branch_taken;
  logic             PC_write;
  logic             IF_ID_write;
  logic             ID_EX_bubble;
  logic             IF_ID_flush;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  // Pipeline side: presents stage fields, consumes controls.
  modport master (
    output IF_ID_rs, IF_ID_rt, IF_ID_UseRs, IF_ID_UseRt, IF_ID_Branch,
           ID_EX_regres, ID_EX_MEMRead, ID_EX_RegWrite,
           EX_MEM_regres, EX_MEM_MEMRead, EX_MEM_RegWrite, branch_taken,
    input  PC_write, IF_ID_write, ID_EX_bubble, IF_ID_flush,
           stall_cycles, flush_count
  );

  // Controller side.
  modport slave (
    input  IF_ID_rs, IF_ID_rt, IF_ID_UseRs, IF_ID_UseRt, IF_ID_Branch,
           ID_EX_regres, ID_EX_MEMRead, ID_EX_RegWrite,
           EX_MEM_regres, EX_MEM_MEMRead, EX_MEM_RegWrite, branch_taken,
    output PC_write, IF_ID_write, ID_EX_bubble, IF_ID_flush,
           stall_cycles, flush_count
  );
endinterface

// File: rtl/id_hazard_ctrl.sv
// ID-stage hazard/stall controller. Stalls on dependencies the ID forwarding
// muxes cannot cover, holds a second cycle for load->branch, squashes the
// wrong-path fetch after a taken branch, and counts stalls and flushes.
module id_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  id_hazard_ctrl_if.slave  bus
);
  typedef enum logic {RUN, HOLD} state_t;

  state_t     state, state_nxt;
  logic [1:0] need;
  logic       stall;
  logic       flush;
  logic       hit_ex, hit_mem;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  function automatic logic match(input logic [4:0] dst);
    return (dst != 5'd0) &&
           ((bus.IF_ID_UseRs && bus.IF_ID_rs == dst) ||
            (bus.IF_ID_UseRt && bus.IF_ID_rt == dst));
  endfunction

  // Stall demand: loads feeding a branch need two cycles, everything else
  // the forwarding network cannot reach needs one.
  always_comb begin
    hit_ex  = bus.ID_EX_RegWrite && match(bus.ID_EX_regres);
    hit_mem = bus.EX_MEM_RegWrite && bus.EX_MEM_MEMRead && match(bus.EX_MEM_regres);
    need    = 2'd0;
    if (bus.IF_ID_Branch) begin
      if (hit_ex && bus.ID_EX_MEMRead)       need = 2'd2;
      else if (hit_ex || hit_mem)            need = 2'd1;
    end else if (hit_ex && bus.ID_EX_MEMRead) begin
      need = 2'd1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // Next state and stall/flush decode; reset forces the non-stalled outputs.
  always_comb begin
    state_nxt = RUN;
    stall     = 1'b0;
    case (state)
      RUN: begin
        stall     = (need != 2'd0);
        state_nxt = (need == 2'd2) ? HOLD : RUN;
      end
      HOLD: begin
        stall     = 1'b1;
        state_nxt = RUN;
      end
      default: begin
        stall     = 1'b0;
        state_nxt = RUN;
      end
    endcase
    if (rst) stall = 1'b0;
    // Branch outcome is meaningless while its operands are still pending.
    flush = !rst && bus.IF_ID_Branch && bus.branch_taken && !stall;
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && stall_cnt != {CNT_W{1'b1}}) stall_cnt <= stall_cnt + 1'b1;
      if (flush && flush_cnt != {CNT_W{1'b1}}) flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign bus.PC_write     = !stall;
  assign bus.IF_ID_write  = !stall;
  assign bus.ID_EX_bubble = stall;
  assign bus.IF_ID_flush  = flush;
  assign bus.stall_cycles = stall_cnt;
  assign bus.flush_count  = flush_cnt;
endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed bench for id_hazard_ctrl: each cycle's expected controls are
// queued with the stimulus and popped/compared mid-cycle.
module tb_id_hazard_ctrl;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  id_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();
  id_hazard_ctrl #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    string tag;
    logic  stall;
    logic  flush;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  logic [CNT_W-1:0] m_sc = '0, m_fc = '0;
  bit cnt_ok = 0;

  task automatic chk(input string tag, input logic [CNT_W-1:0] obs, input logic [CNT_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    bus.IF_ID_rs = 0; bus.IF_ID_rt = 0; bus.IF_ID_UseRs = 0; bus.IF_ID_UseRt = 0;
    bus.IF_ID_Branch = 0; bus.ID_EX_regres = 0; bus.ID_EX_MEMRead = 0;
    bus.ID_EX_RegWrite = 0; bus.EX_MEM_regres = 0; bus.EX_MEM_MEMRead = 0;
    bus.EX_MEM_RegWrite = 0; bus.branch_taken = 0;
  endtask

  task automatic ex_prod(input logic [4:0] d, input logic ld);
    bus.ID_EX_regres = d; bus.ID_EX_MEMRead = ld; bus.ID_EX_RegWrite = 1;
  endtask

  task automatic id_instr(input logic br, input logic [4:0] rs, input logic urs,
                          input logic [4:0] rt, input logic urt);
    bus.IF_ID_Branch = br; bus.IF_ID_rs = rs; bus.IF_ID_UseRs = urs;
    bus.IF_ID_rt = rt; bus.IF_ID_UseRt = urt;
  endtask

  // One clock cycle with inputs already applied.
  task automatic cyc(input string tag, input logic e_stall, input logic e_flush);
    exp_t e;
    exp_q.push_back('{tag, e_stall, e_flush});
    @(negedge clk);
    e = exp_q.pop_front();
    chk({e.tag, ".pc_write"},    CNT_W'(bus.PC_write),     CNT_W'(!e.stall));
    chk({e.tag, ".if_id_write"}, CNT_W'(bus.IF_ID_write),  CNT_W'(!e.stall));
    chk({e.tag, ".bubble"},      CNT_W'(bus.ID_EX_bubble), CNT_W'(e.stall));
    chk({e.tag, ".flush"},       CNT_W'(bus.IF_ID_flush),  CNT_W'(e.flush));
    if (cnt_ok) begin
      chk({e.tag, ".stall_cycles"}, bus.stall_cycles, m_sc);
      chk({e.tag, ".flush_count"},  bus.flush_count,  m_fc);
    end
    if (rst) begin
      m_sc = '0; m_fc = '0; cnt_ok = 1;
    end else begin
      if (e.stall && m_sc != CMAX) m_sc++;
      if (e.flush && m_fc != CMAX) m_fc++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr();
    // Reset with load->branch hazard and a taken branch presented.
    rst = 1;
    id_instr(1, 2, 1, 3, 1); ex_prod(2, 1); bus.branch_taken = 1;
    #1;
    cyc("rst0", 0, 0);
    cyc("rst1", 0, 0);
    rst = 0; clr();
    cyc("idle", 0, 0);

    // lw $2 in EX, beq $2,$3 in ID: two stall cycles.
    id_instr(1, 2, 1, 3, 1); ex_prod(2, 1);
    cyc("h2_c1", 1, 0);
    bus.ID_EX_RegWrite = 0; bus.ID_EX_MEMRead = 0; bus.ID_EX_regres = 0;
    bus.EX_MEM_regres = 2; bus.EX_MEM_MEMRead = 1; bus.EX_MEM_RegWrite = 1;
    bus.branch_taken = 1;
    cyc("h2_c2", 1, 0);
    clr(); id_instr(1, 2, 1, 3, 1);
    cyc("h2_rel", 0, 0);

    // add $4 in EX, beq $4,$0.
    clr(); id_instr(1, 4, 1, 0, 1); ex_prod(4, 0);
    cyc("h1_stall", 1, 0);
    bus.ID_EX_RegWrite = 0; bus.ID_EX_regres = 0;
    cyc("h1_rel", 0, 0);
    ex_prod(0, 0);
    cyc("h1_r0", 0, 0);

    // Load in MEM feeding a branch; ALU result in MEM is forwarded.
    clr(); id_instr(1, 9, 1, 0, 0);
    bus.EX_MEM_regres = 9; bus.EX_MEM_MEMRead = 1; bus.EX_MEM_RegWrite = 1;
    cyc("h3_stall", 1, 0);
    bus.EX_MEM_MEMRead = 0;
    cyc("exmem_alu_fwd", 0, 0);

    // lw $5 in EX, add $6,$5,$7 in ID.
    clr(); id_instr(0, 5, 1, 7, 1); ex_prod(5, 1);
    cyc("h4_stall", 1, 0);
    id_instr(0, 5, 0, 7, 1);
    cyc("h4_nors", 0, 0);

    // Taken branch without hazard.
    clr(); id_instr(1, 1, 1, 3, 1); bus.branch_taken = 1;
    cyc("flush", 0, 1);
    bus.branch_taken = 0;
    cyc("flush_end", 0, 0);

    // Long load-use run saturates the stall counter.
    clr(); id_instr(0, 5, 1, 7, 1); ex_prod(5, 1);
    for (int i = 0; i < 20; i++) cyc($sformatf("sat%0d", i), 1, 0);
    clr();
    cyc("sat_after", 0, 0);
    chk("sat_value", bus.stall_cycles, CMAX);

    // Reset during HOLD aborts the second stall cycle.
    id_instr(1, 2, 1, 3, 1); ex_prod(2, 1);
    cyc("hold_c1", 1, 0);
    rst = 1; #1;
    cyc("hold_rst", 0, 0);
    rst = 0; clr();
    cyc("post_rst", 0, 0);
    chk("post_rst_sc", bus.stall_cycles, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
